// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

    // Memory-freeze FSM: RUN is normal flow, MEM_WAIT holds the pipe for a slow access.
    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    // Register $zero never creates a dependency.
    localparam logic [4:0] REG_ZERO = 5'd0;

    // Default number of extra cycles a data-memory access holds MEM.
    localparam int MEM_WAIT_CYCLES_DEF = 2;

    // Width of the freeze down-counter (covers 0..15).
    localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with a synchronous clear that beats increment.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] r_cnt;

    // Count events, stick at all-ones, clear takes priority over counting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign cnt = r_cnt;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for a 5-stage MIPS pipeline: load-use stalls,
// EX-stage redirects and multi-cycle data-memory freezes, plus perf counters.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_WAIT_CYCLES = MEM_WAIT_CYCLES_DEF,
    parameter int CNT_W           = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       Rs_ID,
    input  logic [4:0]       Rt_ID,
    input  logic             UseRs_ID,
    input  logic             UseRt_ID,
    input  logic             MemRead_EX,
    input  logic [4:0]       Rt_EX,
    input  logic             Redirect_EX,
    input  logic             MemAccess_MEM,
    input  logic             perf_clear,
    output logic             Enable_PC,
    output logic             Enable_IF_ID,
    output logic             Enable_ID_EX,
    output logic             Enable_EX_MEM,
    output logic             Enable_MEM_WB,
    output logic             Flush_IF_ID,
    output logic             Flush_ID_EX,
    output logic             PCSrc_Redirect,
    output logic             mem_busy,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    localparam bit                    HAS_WAIT  = (MEM_WAIT_CYCLES > 0);
    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
        WAIT_CNT_W'(HAS_WAIT ? (MEM_WAIT_CYCLES - 1) : 0);

    state_t                r_state;
    state_t                w_next_state;
    logic [WAIT_CNT_W-1:0] r_wait_cnt;
    logic [WAIT_CNT_W-1:0] w_next_wait_cnt;

    logic w_load_use;
    logic w_freeze;

    // A load in EX whose destination is read by the ID instruction.
    assign w_load_use = MemRead_EX && (Rt_EX != REG_ZERO) &&
                        ((UseRs_ID && (Rs_ID == Rt_EX)) ||
                         (UseRt_ID && (Rt_ID == Rt_EX)));

    // The release cycle (MEM_WAIT, count 0) is not frozen and ignores MemAccess_MEM.
    assign w_freeze = ((r_state == RUN) && MemAccess_MEM && HAS_WAIT) ||
                      ((r_state == MEM_WAIT) && (r_wait_cnt != '0));

    // State register and freeze down-counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_next_state;
            r_wait_cnt <= w_next_wait_cnt;
        end
    end

    // Next-state: enter MEM_WAIT on a new access, count down, then return to RUN.
    always_comb begin
        w_next_state    = r_state;
        w_next_wait_cnt = r_wait_cnt;
        case (r_state)
            RUN: begin
                if (MemAccess_MEM && HAS_WAIT) begin
                    w_next_state    = MEM_WAIT;
                    w_next_wait_cnt = WAIT_LOAD;
                end
            end
            MEM_WAIT: begin
                if (r_wait_cnt != '0) begin
                    w_next_wait_cnt = r_wait_cnt - 1'b1;
                end else begin
                    w_next_state = RUN;
                end
            end
            default: begin
                w_next_state    = RUN;
                w_next_wait_cnt = '0;
            end
        endcase
    end

    // Output decode by priority: freeze, redirect, load-use, normal flow.
    always_comb begin
        Enable_PC      = 1'b1;
        Enable_IF_ID   = 1'b1;
        Enable_ID_EX   = 1'b1;
        Enable_EX_MEM  = 1'b1;
        Enable_MEM_WB  = 1'b1;
        Flush_IF_ID    = 1'b0;
        Flush_ID_EX    = 1'b0;
        PCSrc_Redirect = 1'b0;
        if (!reset) begin
            if (w_freeze) begin
                // Whole pipe holds; a pending redirect or load-use waits for release.
                Enable_PC     = 1'b0;
                Enable_IF_ID  = 1'b0;
                Enable_ID_EX  = 1'b0;
                Enable_EX_MEM = 1'b0;
                Enable_MEM_WB = 1'b0;
            end else if (Redirect_EX) begin
                // Squash IF and ID; this also cancels any load-use on the ID instruction.
                Flush_IF_ID    = 1'b1;
                Flush_ID_EX    = 1'b1;
                PCSrc_Redirect = 1'b1;
            end else if (w_load_use) begin
                // Hold PC and IF_ID one cycle, inject a bubble into EX.
                Enable_PC    = 1'b0;
                Enable_IF_ID = 1'b0;
                Flush_ID_EX  = 1'b1;
            end
        end
    end

    assign mem_busy = (r_state == MEM_WAIT);

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk (clk),
        .rst (reset),
        .inc (~Enable_PC),
        .clr (perf_clear),
        .cnt (stall_cycles)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_flush_cnt (
        .clk (clk),
        .rst (reset),
        .inc (PCSrc_Redirect),
        .clr (perf_clear),
        .cnt (flush_events)
    );

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage MIPS pipeline (IF, ID, EX, MEM, WB).
- Drives the enable and flush inputs of the PC and the IF_ID, ID_EX, EX_MEM and MEM_WB pipeline registers.
- Resolves three hazard classes: load-use, control redirect (branch, J, JR, JAL taken in EX) and multi-cycle data-memory wait.
- Keeps saturating performance counters for stall cycles and flush events.

Parameters:
- MEM_WAIT_CYCLES, 2, extra cycles a data-memory access holds the MEM stage; 0 means no memory freeze (valid range 0..15).
- CNT_W, 32, width of each performance counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- Rs_ID  input  5  rs field of the instruction in ID.
- Rt_ID  input  5  rt field of the instruction in ID.
- UseRs_ID  input  1  ID instruction reads rs.
- UseRt_ID  input  1  ID instruction reads rt.
- MemRead_EX  input  1  instruction in EX is a load.
- Rt_EX  input  5  load destination register in EX.
- Redirect_EX  input  1  EX resolved a taken branch, J, JAL or JR.
- MemAccess_MEM  input  1  instruction in MEM reads or writes data memory.
- perf_clear  input  1  synchronous clear of both counters.
- Enable_PC, Enable_IF_ID, Enable_ID_EX, Enable_EX_MEM, Enable_MEM_WB  output  1 each  register load enables.
- Flush_IF_ID  output  1  load a NOP into IF_ID.
- Flush_ID_EX  output  1  load zeroed controls (bubble) into ID_EX.
- PCSrc_Redirect  output  1  PC mux selects the EX target.
- mem_busy  output  1  FSM is in MEM_WAIT.
- stall_cycles  output  CNT_W  count of cycles with Enable_PC=0.
- flush_events  output  CNT_W  count of cycles with redirect applied.

Behaviour:
- Reset: state=RUN, wait_cnt=0, both counters=0.
- Outputs while reset is high: all enables=1, all flushes=0, PCSrc_Redirect=0, mem_busy=0.
- Enable, flush and PCSrc outputs are combinational from state, wait_cnt and the current inputs. They take effect at the same rising edge.
- load_use = MemRead_EX && Rt_EX!=0 && ((UseRs_ID && Rs_ID==Rt_EX) || (UseRt_ID && Rt_ID==Rt_EX)).
- freeze is true when either:
  - state=RUN && MemAccess_MEM && MEM_WAIT_CYCLES>0, or
  - state=MEM_WAIT && wait_cnt!=0.
- Output priority, highest first:
  1. freeze: all five enables=0, flushes=0, PCSrc_Redirect=0. Any redirect or load-use is held, not applied.
  2. Redirect_EX: all enables=1, Flush_IF_ID=1, Flush_ID_EX=1, PCSrc_Redirect=1. Load-use is ignored because the ID instruction is squashed.
  3. load_use: Enable_PC=0, Enable_IF_ID=0, Flush_ID_EX=1. EX/MEM/WB enables=1. The stall lasts exactly 1 cycle, because the next cycle the load has left EX.
  4. Otherwise: all enables=1, flushes=0.
- FSM transitions:
  - RUN -> MEM_WAIT when MemAccess_MEM && MEM_WAIT_CYCLES>0; load wait_cnt=MEM_WAIT_CYCLES-1.
  - MEM_WAIT with wait_cnt!=0: decrement wait_cnt.
  - MEM_WAIT with wait_cnt==0 (release cycle): not frozen, so priorities 2-4 apply; next state=RUN.
  - In the release cycle MemAccess_MEM refers to the access being released and is ignored. Only one freeze occurs per access.
- Freeze timing: total freeze = MEM_WAIT_CYCLES cycles per access. With MEM_WAIT_CYCLES=0 the FSM never leaves RUN.
- Back-to-back accesses: the access entering MEM after a release triggers a new freeze in the following RUN cycle.
- Counters:
  - stall_cycles += 1 on every cycle with Enable_PC=0.
  - flush_events += 1 on every cycle with PCSrc_Redirect=1.
  - Both saturate at all-ones.
  - perf_clear has priority over increment. A clear in the same cycle as an event leaves the counter at 0.
- Reset asserted mid-MEM_WAIT: immediate return to RUN with wait_cnt=0. Outputs revert to reset values asynchronously.
- mem_busy = (state==MEM_WAIT).

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - state typedef {RUN, MEM_WAIT};
  - REG_ZERO=5'd0;
  - the default MEM_WAIT_CYCLES constant.
- Sub-module sat_counter (parameter CNT_W; inputs inc and clr), instantiated twice. Hazard decode and FSM stay in the top module.

Test Plan:
- Load-use: MemRead_EX=1, Rt_EX=8, Rs_ID=8, UseRs_ID=1 for one cycle -> Enable_PC=0, Enable_IF_ID=0, Flush_ID_EX=1 that cycle; stall_cycles=1. Repeat with Rt_EX=0 -> no stall.
- Redirect + load-use in the same cycle -> Flush_IF_ID=1, Flush_ID_EX=1, PCSrc_Redirect=1, Enable_PC=1; flush_events=1; stall_cycles unchanged.
- MEM_WAIT_CYCLES=2, MemAccess_MEM pulse at cycle 0 -> all enables 0 in cycles 0-1, mem_busy=1 in cycles 1-2, enables 1 in cycle 2; stall_cycles=2.
- Redirect_EX held high during the freeze -> PCSrc_Redirect=0 while frozen, 1 in the release cycle, flush_events=1.
- Reset asserted in cycle 1 of MEM_WAIT -> mem_busy=0 and enables=1 immediately; counters=0; state=RUN after release.
- Force stall_cycles to all-ones minus 1, then 3 stall cycles -> holds at all-ones. perf_clear together with a stall -> 0.
